regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
Initiator-side controller for the 8x16 register file. The register file has combinational reads, a synchronous write and no reset. This block drives its address, write-enable and write-data lines and captures its read data. After reset it sweeps every register to a known value, then serves single-outstanding read-pair and write requests from the multi-cycle datapath over a valid/ready handshake.

Parameters:
DW, 16, data width of register-file words
AW, 3, register address width
NREG, 8, number of registers swept at init; must equal 2**AW
INIT_VAL, 16'h0000, value written to every register during init sweep

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_write  in  1  1 = write request, 0 = read-pair request
req_ra1  in  AW  read address 1
req_ra2  in  AW  read address 2
req_wa  in  AW  write address
req_wd  in  DW  write data
rsp_valid  out  1  read response held valid
rsp_ready  in  1  consumer accepts response
rsp_rd1  out  DW  captured data for req_ra1
rsp_rd2  out  DW  captured data for req_ra2
busy  out  1  state != IDLE
rf_we  out  1  register-file write enable
rf_a1  out  AW  register-file read address 1
rf_a2  out  AW  register-file read address 2
rf_a3  out  AW  register-file write address
rf_wd  out  DW  register-file write data
rf_rd1  in  DW  register-file read data 1 (combinational from rf_a1)
rf_rd2  in  DW  register-file read data 2 (combinational from rf_a2)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst): sampled only on the rising edge of clk.
- States: INIT, IDLE, READ, WRITE, RESP. Internal registers: cnt (AW+1 bits), ra1_q, ra2_q, wa_q, wd_q, rd1_q, rd2_q.
- Reset (rst=1 at an edge), including mid-operation:
  - state<=INIT, cnt<=0.
  - ra1_q, ra2_q, wa_q, wd_q, rd1_q, rd2_q <= 0.
  - Any pending request or response is dropped.
- Outputs decode from state and registers:
  - rf_we=1 in INIT or WRITE, else 0.
  - In INIT: rf_a3=cnt[AW-1:0] and rf_wd=INIT_VAL. Otherwise rf_a3=wa_q and rf_wd=wd_q.
  - rf_a1=ra1_q, rf_a2=ra2_q.
  - rsp_rd1=rd1_q, rsp_rd2=rd2_q.
  - req_ready=(state==IDLE); rsp_valid=(state==RESP); busy=(state!=IDLE).
- Values after a reset edge: state INIT, rf_we=1, rf_a3=0, rf_wd=INIT_VAL, req_ready=0, rsp_valid=0, busy=1, all other outputs 0.
- INIT:
  - Each edge with rst=0: cnt<=cnt+1.
  - At the edge where cnt==NREG-1: state<=IDLE.
  - Exactly NREG write cycles occur after rst deasserts; req_ready first rises NREG edges after the first edge with rst=0.
- IDLE: at an edge with req_valid=1, capture the request.
  - Write (req_write=1): wa_q<=req_wa, wd_q<=req_wd, state<=WRITE.
  - Read (req_write=0): ra1_q<=req_ra1, ra2_q<=req_ra2, state<=READ.
  - Inputs are ignored when req_ready=0.
- WRITE:
  - One cycle with rf_we=1. The register file commits at the next edge; state<=IDLE.
  - Writes generate no response.
  - Write-to-accept latency is 2 edges: a new request is accepted earliest 2 edges after the write was accepted.
- READ:
  - rf_a1/rf_a2 are stable for the whole cycle.
  - At the next edge: rd1_q<=rf_rd1, rd2_q<=rf_rd2, state<=RESP.
  - rsp_valid rises 2 edges after the read request is accepted.
- RESP:
  - rsp_valid and the data are held stable until an edge with rsp_ready=1, then state<=IDLE.
  - rsp_ready while not in RESP is ignored.
- Read-after-write: a read issued after a write's WRITE cycle returns the new value; single-outstanding operation guarantees this.
- Addresses wrap within AW bits; there are no out-of-range cases.

Test Plan:
- Init sweep: assert rst for 3 cycles, release → rf_we=1 for exactly 8 cycles with rf_a3=0..7 and rf_wd=0x0000; req_ready rises at the 8th edge after release.
- Write then read: write r5=0xBEEF, then read ra1=5, ra2=0 → rf_we pulses once with rf_a3=5; rsp_valid rises 2 edges after the read is accepted with rsp_rd1=0xBEEF, rsp_rd2=0x0000.
- Response backpressure: read r5/r5 with rsp_ready=0 for 4 cycles → rsp_valid and rsp_rd1=rsp_rd2=0xBEEF held stable; req_ready stays 0 and a new req_valid is ignored until rsp_ready=1.
- Back-to-back writes: req_valid held high, writing r1=0x1111 then r2=0x2222 → accepts are 2 edges apart, 2 rf_we pulses total, and a subsequent read of r1/r2 returns 0x1111/0x2222.
- Reset mid-read: assert rst during RESP → rsp_valid=0 after the edge, the full 8-register sweep repeats, and a read of r5 afterwards returns 0x0000.
- Init ignore: hold req_valid=1 with req_write=1 during INIT → no write from the request occurs before IDLE; it is accepted on the first IDLE edge.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for an 8x16 register file: init sweep, then single-outstanding read-pair / write requests.
// Latency: write accepted -> rf_we next cycle (re-accept after 2 edges); read accepted -> rsp_valid after 2 edges.
// Backpressure: req_ready only in IDLE; a response is held in RESP until rsp_ready, stalling new requests.
module regfile_access_ctrl #(
    parameter int              DW       = 16,
    parameter int              AW       = 3,
    parameter int              NREG     = 8,
    parameter logic [DW-1:0]   INIT_VAL = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_ra1,
    input  logic [AW-1:0] req_ra2,
    input  logic [AW-1:0] req_wa,
    input  logic [DW-1:0] req_wd,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rd1,
    output logic [DW-1:0] rsp_rd2,
    output logic          busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_a1,
    output logic [AW-1:0] rf_a2,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Last sweep index; the counter is one bit wider than an address.
    localparam logic [AW:0] CNT_LAST = (AW+1)'(NREG - 1);

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q,   cnt_d;
    logic [AW-1:0] ra1_q,   ra1_d;
    logic [AW-1:0] ra2_q,   ra2_d;
    logic [AW-1:0] wa_q,    wa_d;
    logic [DW-1:0] wd_q,    wd_d;
    logic [DW-1:0] rd1_q,   rd1_d;
    logic [DW-1:0] rd2_q,   rd2_d;

    // State and datapath registers; reset drops any request or response in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ra1_q   <= ra1_d;
            ra2_q   <= ra2_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    // Next-state logic: sweep, accept one request, run its single access cycle, hold any response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ra1_d   = ra1_q;
        ra2_d   = ra2_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        wa_d    = req_wa;
                        wd_d    = req_wd;
                        state_d = S_WRITE;
                    end else begin
                        ra1_d   = req_ra1;
                        ra2_d   = req_ra2;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                // Read addresses have been stable all cycle, so the combinational data is settled here.
                rd1_d   = rf_rd1;
                rd2_d   = rf_rd2;
                state_d = S_RESP;
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Register-file drive: the sweep owns the write port during INIT, the captured request otherwise.
    assign rf_we     = (state_q == S_INIT) || (state_q == S_WRITE);
    assign rf_a3     = (state_q == S_INIT) ? cnt_q[AW-1:0] : wa_q;
    assign rf_wd     = (state_q == S_INIT) ? INIT_VAL : wd_q;
    assign rf_a1     = ra1_q;
    assign rf_a2     = ra2_q;

    assign rsp_rd1   = rd1_q;
    assign rsp_rd2   = rd2_q;
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl with a behavioural 8x16 register file attached.
// Table of per-cycle vectors for reset/init/write/read, then hand-written multi-cycle sequences.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that point too.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_ra1, req_ra2, req_wa;
    logic [15:0] req_wd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rd1, rsp_rd2;
    logic        busy;
    logic        rf_we;
    logic [2:0]  rf_a1, rf_a2, rf_a3;
    logic [15:0] rf_wd, rf_rd1, rf_rd2;

    int n_cmp  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int wc0;

    logic [15:0] mem [8];

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DW(16), .AW(3), .NREG(8), .INIT_VAL(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_ra1(req_ra1), .req_ra2(req_ra2), .req_wa(req_wa), .req_wd(req_wd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2), .busy(busy),
        .rf_we(rf_we), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
    );

    // Register file: no reset of its own; junk is loaded while rst is high so the sweep is observable.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'hA5A0 + 16'(i);
        end else if (rf_we) begin
            mem[rf_a3] <= rf_wd;
        end
    end
    assign rf_rd1 = mem[rf_a1];
    assign rf_rd2 = mem[rf_a2];

    // Count register-file write cycles seen at clock edges.
    always @(posedge clk) begin
        if (rf_we) we_cnt <= we_cnt + 1;
    end

    typedef struct {
        string       name;
        logic        rst, vld, wr;
        logic [2:0]  ra1, ra2, wa;
        logic [15:0] wd;
        logic        rrdy;
        logic        e_rdy, e_rv, e_busy, e_we;
        logic [2:0]  e_a1, e_a2, e_a3;
        logic [15:0] e_wd, e_rd1, e_rd2;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic r, input logic v, input logic w,
                       input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] wa,
                       input logic [15:0] wd, input logic rr,
                       input logic erdy, input logic erv, input logic ebusy, input logic ewe,
                       input logic [2:0] ea1, input logic [2:0] ea2, input logic [2:0] ea3,
                       input logic [15:0] ewd, input logic [15:0] erd1, input logic [15:0] erd2);
        vec_t t;
        t.name = nm; t.rst = r; t.vld = v; t.wr = w; t.ra1 = a1; t.ra2 = a2; t.wa = wa;
        t.wd = wd; t.rrdy = rr; t.e_rdy = erdy; t.e_rv = erv; t.e_busy = ebusy; t.e_we = ewe;
        t.e_a1 = ea1; t.e_a2 = ea2; t.e_a3 = ea3; t.e_wd = ewd; t.e_rd1 = erd1; t.e_rd2 = erd2;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [2:0] a1,
                           input logic [2:0] a2, input logic [2:0] wa, input logic [15:0] wd);
        req_valid = v; req_write = w; req_ra1 = a1; req_ra2 = a2; req_wa = wa; req_wd = wd;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);

        // name      rst v w ra1 ra2 wa wd rrdy | rdy rv busy we a1 a2 a3 wd rd1 rd2
        add("rst0", 1, 0, 0, 0, 0, 0, 16'h0, 0,  0, 0, 1, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        add("rst1", 1, 0, 0, 0, 0, 0, 16'h0, 0,  0, 0, 1, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        add("rst2", 1, 0, 0, 0, 0, 0, 16'h0, 0,  0, 0, 1, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        for (int k = 1; k < 8; k++)
            add($sformatf("init%0d", k), 0, 0, 0, 0, 0, 0, 16'h0, 0,
                0, 0, 1, 1, 0, 0, 3'(k), 16'h0, 16'h0, 16'h0);
        add("idle",    0, 0, 0, 0, 0, 0, 16'h0,    1,  1, 0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    16'h0);
        add("wr_acc",  0, 1, 1, 0, 0, 5, 16'hBEEF, 0,  0, 0, 1, 1, 0, 0, 5, 16'hBEEF, 16'h0,    16'h0);
        add("wr_done", 0, 0, 0, 0, 0, 0, 16'h0,    0,  1, 0, 0, 0, 0, 0, 5, 16'hBEEF, 16'h0,    16'h0);
        add("rd_acc",  0, 1, 0, 5, 0, 0, 16'h0,    0,  0, 0, 1, 0, 5, 0, 5, 16'hBEEF, 16'h0,    16'h0);
        add("rd_resp", 0, 0, 0, 0, 0, 0, 16'h0,    0,  0, 1, 1, 0, 5, 0, 5, 16'hBEEF, 16'hBEEF, 16'h0);
        add("rd_done", 0, 0, 0, 0, 0, 0, 16'h0,    1,  1, 0, 0, 0, 5, 0, 5, 16'hBEEF, 16'hBEEF, 16'h0);

        foreach (vq[i]) begin
            rst = vq[i].rst; rsp_ready = vq[i].rrdy;
            set_req(vq[i].vld, vq[i].wr, vq[i].ra1, vq[i].ra2, vq[i].wa, vq[i].wd);
            step();
            chk({vq[i].name, ".req_ready"}, 16'(req_ready), 16'(vq[i].e_rdy));
            chk({vq[i].name, ".rsp_valid"}, 16'(rsp_valid), 16'(vq[i].e_rv));
            chk({vq[i].name, ".busy"},      16'(busy),      16'(vq[i].e_busy));
            chk({vq[i].name, ".rf_we"},     16'(rf_we),     16'(vq[i].e_we));
            chk({vq[i].name, ".rf_a1"},     16'(rf_a1),     16'(vq[i].e_a1));
            chk({vq[i].name, ".rf_a2"},     16'(rf_a2),     16'(vq[i].e_a2));
            chk({vq[i].name, ".rf_a3"},     16'(rf_a3),     16'(vq[i].e_a3));
            chk({vq[i].name, ".rf_wd"},     rf_wd,          vq[i].e_wd);
            chk({vq[i].name, ".rsp_rd1"},   rsp_rd1,        vq[i].e_rd1);
            chk({vq[i].name, ".rsp_rd2"},   rsp_rd2,        vq[i].e_rd2);
        end
        rsp_ready = 1'b0;

        // Response backpressure: read r5/r5, hold rsp_ready low 4 cycles with a competing write request.
        set_req(1'b1, 1'b0, 3'd5, 3'd5, 3'd0, 16'h0);
        step();
        chk("bp.read_busy", 16'(busy), 16'd1);
        set_req(1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 16'h7777);
        wc0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp.rsp_valid", 16'(rsp_valid), 16'd1);
            chk("bp.rsp_rd1",   rsp_rd1,        16'hBEEF);
            chk("bp.rsp_rd2",   rsp_rd2,        16'hBEEF);
            chk("bp.req_ready", 16'(req_ready), 16'd0);
        end
        chk("bp.no_write", 16'(we_cnt - wc0), 16'd0);
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp.release_valid", 16'(rsp_valid), 16'd0);
        chk("bp.release_ready", 16'(req_ready), 16'd1);

        // Back-to-back writes with req_valid held high: accepts land 2 edges apart.
        wc0 = we_cnt;
        set_req(1'b1, 1'b1, 3'd0, 3'd0, 3'd1, 16'h1111);
        step();
        chk("b2b.w1_we", 16'(rf_we), 16'd1);
        chk("b2b.w1_a3", 16'(rf_a3), 16'd1);
        set_req(1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 16'h2222);
        step();
        chk("b2b.gap_ready", 16'(req_ready), 16'd1);
        chk("b2b.gap_we",    16'(rf_we),     16'd0);
        step();
        chk("b2b.w2_we", 16'(rf_we), 16'd1);
        chk("b2b.w2_a3", 16'(rf_a3), 16'd2);
        chk("b2b.w2_wd", rf_wd,      16'h2222);
        req_valid = 1'b0;
        step();
        chk("b2b.we_pulses", 16'(we_cnt - wc0), 16'd2);
        set_req(1'b1, 1'b0, 3'd1, 3'd2, 3'd0, 16'h0);
        step();
        req_valid = 1'b0;
        step();
        chk("b2b.rsp_valid", 16'(rsp_valid), 16'd1);
        chk("b2b.rd1",       rsp_rd1,        16'h1111);
        chk("b2b.rd2",       rsp_rd2,        16'h2222);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("b2b.idle", 16'(req_ready), 16'd1);

        // Reset during RESP, with a write request held through the whole init sweep.
        set_req(1'b1, 1'b0, 3'd5, 3'd5, 3'd0, 16'h0);
        step();
        req_valid = 1'b0;
        step();
        chk("mid.rsp_valid_before", 16'(rsp_valid), 16'd1);
        rst = 1'b1;
        set_req(1'b1, 1'b1, 3'd0, 3'd0, 3'd3, 16'h3333);
        step();
        chk("mid.rsp_valid_after", 16'(rsp_valid), 16'd0);
        chk("mid.busy",            16'(busy),      16'd1);
        chk("mid.rf_we",           16'(rf_we),     16'd1);
        chk("mid.rf_a3",           16'(rf_a3),     16'd0);
        chk("mid.rf_a1",           16'(rf_a1),     16'd0);
        chk("mid.rsp_rd1",         rsp_rd1,        16'h0);
        rst = 1'b0;
        wc0 = we_cnt;
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("mid.sweep_a3_%0d", k), 16'(rf_a3), 16'(k));
            chk("mid.sweep_wd",    rf_wd,          16'h0);
            chk("mid.sweep_ready", 16'(req_ready), 16'd0);
        end
        step();
        chk("mid.ready_rise", 16'(req_ready), 16'd1);
        chk("mid.we_low",     16'(rf_we),     16'd0);
        chk("mid.sweep_cnt",  16'(we_cnt - wc0), 16'd8);
        chk("init_ignore.r3_untouched", mem[3], 16'h0);
        step();
        chk("init_ignore.accept_we", 16'(rf_we), 16'd1);
        chk("init_ignore.accept_a3", 16'(rf_a3), 16'd3);
        chk("init_ignore.accept_wd", rf_wd,      16'h3333);
        req_valid = 1'b0;
        step();
        set_req(1'b1, 1'b0, 3'd5, 3'd3, 3'd0, 16'h0);
        step();
        req_valid = 1'b0;
        step();
        chk("mid.rsp_valid_final", 16'(rsp_valid), 16'd1);
        chk("mid.r5_cleared",      rsp_rd1,        16'h0);
        chk("init_ignore.r3",      rsp_rd2,        16'h3333);
        rsp_ready = 1'b1;
        step();
        chk("mid.final_idle", 16'(req_ready), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
